// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared AXI widths, fetch constants and fetch state type
package ifu_fetch_pkg;

    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_RESP_W  = 2;
    localparam int AXI_WSTRB_W = AXI_DATA_W / 8;

    localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [31:0]           INST_NOP       = 32'h0000_0013;
    localparam logic [31:0]           CPU_RESET_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_RESP = 2'd1,
        FETCH_OUT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit, AXI-lite read master feeding decode
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                ADDR_W   = AXI_ADDR_W,
    parameter int                DATA_W   = AXI_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_ADDR),
    parameter logic [DATA_W-1:0] INST_NOP = DATA_W'(ifu_fetch_pkg::INST_NOP)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [AXI_RESP_W-1:0] rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    output logic                  bready,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_W-1:0]     inst,
    output logic [ADDR_W-1:0]     inst_pc,
    output logic                  fetch_err
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_araddr;
    logic [ADDR_W-1:0] r_inst_pc;
    logic [DATA_W-1:0] r_inst;
    logic              r_squash;
    logic              w_squash_next;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_inst_valid;
    logic              r_fetch_err;
    logic              w_capture;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_inst_hs;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic              w_unused_redirect_lo;

    assign w_redirect_pc        = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_unused_redirect_lo = ^redirect_pc[1:0];
    assign w_ar_hs              = r_arvalid && arready;
    assign w_r_hs               = r_rready && rvalid;
    assign w_inst_hs            = r_inst_valid && inst_ready;

    // A redirect never touches an address already on the bus; the old read is squashed instead.
    always_comb begin
        w_state_next  = r_state;
        w_squash_next = r_squash;
        w_capture     = 1'b0;
        case (r_state)
            FETCH_REQ: begin
                if (w_ar_hs) begin
                    w_state_next = FETCH_RESP;
                end
                if (redirect_valid && r_arvalid) begin
                    w_squash_next = 1'b1;
                end
            end
            FETCH_RESP: begin
                if (w_r_hs) begin
                    w_squash_next = 1'b0;
                    if (r_squash || redirect_valid) begin
                        w_state_next = FETCH_REQ;
                    end else begin
                        w_state_next = FETCH_OUT;
                        w_capture    = 1'b1;
                    end
                end else if (redirect_valid) begin
                    w_squash_next = 1'b1;
                end
            end
            FETCH_OUT: begin
                if (redirect_valid || w_inst_hs) begin
                    w_state_next = FETCH_REQ;
                end
            end
            default: begin
                w_state_next = FETCH_REQ;
            end
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        if (redirect_valid) begin
            w_pc_next = w_redirect_pc;
        end else if (r_state == FETCH_OUT && w_inst_hs) begin
            w_pc_next = r_pc + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= FETCH_REQ;
            r_squash     <= 1'b0;
            r_pc         <= RESET_PC;
            r_araddr     <= RESET_PC;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= INST_NOP;
            r_inst_pc    <= RESET_PC;
            r_fetch_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_squash     <= w_squash_next;
            r_pc         <= w_pc_next;
            r_arvalid    <= (w_state_next == FETCH_REQ);
            r_rready     <= (w_state_next == FETCH_RESP);
            r_inst_valid <= (w_state_next == FETCH_OUT);
            // araddr tracks pc until it is committed to the bus by arvalid
            if (!(r_state == FETCH_REQ && r_arvalid)) begin
                r_araddr <= w_pc_next;
            end
            if (w_capture) begin
                r_inst      <= (rresp == AXI_RESP_OKAY) ? rdata : INST_NOP;
                r_fetch_err <= (rresp != AXI_RESP_OKAY);
                r_inst_pc   <= r_pc;
            end
        end
    end

    assign araddr     = r_araddr;
    assign arvalid    = r_arvalid;
    assign rready     = r_rready;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign fetch_err  = r_fetch_err;

    assign awaddr  = '0;
    assign awvalid = 1'b0;
    assign wdata   = '0;
    assign wstrb   = '0;
    assign wvalid  = 1'b0;
    assign bready  = 1'b0;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit sitting directly upstream of the instruction SRAM AXI-lite slave; acts as the AXI-lite read master.
- Holds the PC, issues one read per instruction and captures the returned word.
- Presents the instruction with its PC to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from later stages and squashes wrong-path fetches, including one already in flight.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- ADDR_W, 32, AXI/PC address width.
- DATA_W, 32, AXI data / instruction width.
- INST_NOP, 32'h0000_0013, word substituted on error or idle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- redirect_valid  in  1  new PC request from a later stage; single-cycle pulse.
- redirect_pc  in  ADDR_W  redirect target.
- araddr  out  ADDR_W  AXI read address.
- arvalid  out  1  AXI read address valid.
- arready  in  1  slave ready for an address.
- rdata  in  DATA_W  AXI read data.
- rresp  in  2  AXI read response; 2'b00 = OKAY.
- rvalid  in  1  read data valid.
- rready  out  1  master ready for read data.
- awaddr/awvalid/wdata/wstrb/wvalid/bready  out  (AXI widths)  write channels, tied to 0.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts.
- inst  out  DATA_W  fetched instruction.
- inst_pc  out  ADDR_W  PC of inst.
- fetch_err  out  1  qualifies inst; set when rresp != OKAY.

Behaviour:
- Reset values (while rst_n=0): arvalid=0, rready=0, inst_valid=0, inst=INST_NOP, inst_pc=RESET_PC, fetch_err=0, pc=RESET_PC, state=REQ, squash=0.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- State REQ:
  - arvalid=1, araddr=pc.
  - On arvalid&&arready, go to RESP.
  - Once raised, arvalid and araddr stay stable until the handshake (AXI rule), even if a redirect arrives.
- State RESP:
  - rready=1.
  - On rvalid with squash=0: latch inst = (rresp==OKAY ? rdata : INST_NOP), fetch_err = (rresp!=OKAY), inst_pc=pc; go to OUT.
  - On rvalid with squash=1: discard the data, clear squash, go to REQ.
- State OUT:
  - inst_valid=1; inst, inst_pc and fetch_err are held stable.
  - On inst_valid&&inst_ready: pc<=pc+4 (modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0); go to REQ.
- Latency: the first arvalid appears in the first cycle after rst_n rises. Minimum per-instruction loop is REQ → RESP → OUT → REQ plus slave wait cycles.
- Redirect handling (redirect_valid=1):
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; misaligned low bits are dropped.
  - REQ, handshake not yet done: pc updates and araddr follows next cycle. This is legal only because araddr is taken from pc and no handshake has occurred; to stay AXI-compliant, when arvalid was already high, set squash=1 and keep the old address instead.
  - REQ with handshake in the same cycle, or RESP: set squash=1; the response is discarded on arrival.
  - OUT: inst_valid drops next cycle and the state goes to REQ. A same-cycle inst handshake is void: decode is flushed by the same signal and pc does NOT add 4.
  - Redirect in the same cycle as rvalid in RESP: the data is discarded and the state goes to REQ with the new pc.
  - Back-to-back redirects: the last one wins; squash stays a single bit because only one request can be outstanding.
- Only one AXI read is outstanding at any time.
- Reset mid-transaction returns to the reset state. The slave shares the reset, so no stale response is expected.

Decomposition:
- Shared defines package holds:
  - AXI_ADDR/DATA/RESP/WSTRB widths
  - AXI_RESP_OKAY
  - INST_NOP
  - CPU_RESET_ADDR
  - the fetch state enum {REQ, RESP, OUT}
- Single flat module. PC next-value logic is small enough to stay inline, so no sub-module.

Test Plan:
- Reset then connect the SRAM slave returning 32'h0010_0093 at 0x8000_0000 with inst_ready=1 → arvalid high in the first cycle after reset with araddr=0x8000_0000; inst=0x0010_0093, inst_pc=0x8000_0000; next araddr=0x8000_0004.
- Hold inst_ready=0 for 5 cycles → inst_valid stays 1, inst/inst_pc stable, no new arvalid; on release, pc advances by exactly 4.
- Redirect to 0x8000_0102 while in RESP → response for the old address is dropped (inst_valid never asserts for it); next araddr=0x8000_0100.
- Redirect in OUT in the same cycle as inst_ready=1 → pc ≠ old+4; next araddr=redirect target.
- rresp=2'b10 → inst=0x0000_0013, fetch_err=1, inst_valid=1.
- pc=0xFFFF_FFFC accepted → next araddr=0x0000_0000; reset asserted during RESP → all outputs return to their reset values next cycle.
